// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - video timing and test-pattern generator (optional border: VPG_BORDER_EN)
module vga_pattern_gen #(
  parameter int TW         = 12,
  parameter int CW         = 8,
  parameter int BAR_SHIFT  = 6,
  parameter int GRID_SHIFT = 5,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [TW-1:0]   h_total,
  input  logic [TW-1:0]   v_total,
  input  logic [TW-1:0]   h_sync,
  input  logic [TW-1:0]   v_sync,
  input  logic [TW-1:0]   h_start,
  input  logic [TW-1:0]   h_end,
  input  logic [TW-1:0]   v_start,
  input  logic [TW-1:0]   v_end,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vga_de,
  output logic [CW-1:0]   vga_r,
  output logic [CW-1:0]   vga_g,
  output logic [CW-1:0]   vga_b,
  output logic [7:0]      frame_cnt,
  output logic            frame_start
);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [TW-1:0] h_count, v_count;
  logic [7:0]    fcnt;
  logic [1:0]    mode_q;
  logic          line_end, frame_end, first_px;
  logic          hs_raw, vs_raw, act;
  logic [TW-1:0] px, py;

  logic          s1_hs, s1_vs, s1_act, s1_first;
  logic [TW-1:0] s1_px, s1_py;
  logic [7:0]    s1_fcnt;
  logic [2:0]    bar;
  logic          grid_on;
  logic [CW-1:0] pat_r, pat_g, pat_b;
  logic          unused_bits;

  // >= rather than == so a shrunk total wraps immediately instead of running to 2^TW
  assign line_end  = (h_count >= h_total);
  assign frame_end = (v_count >= v_total);
  assign first_px  = (h_count == '0) && (v_count == '0);

  assign hs_raw = (h_count < h_sync);
  assign vs_raw = (v_count < v_sync);
  assign act    = (h_count >= h_start) && (h_count < h_end) &&
                  (v_count >= v_start) && (v_count < v_end);
  assign px     = h_count - h_start;
  assign py     = v_count - v_start;

`ifdef VPG_BORDER_EN
  logic border_raw, s1_border;
  assign border_raw = (px == '0) || (h_count == h_end - TW'(1)) ||
                      (py == '0) || (v_count == v_end - TW'(1));
`endif

  // Horizontal/vertical counters and the internal completed-frame count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
      fcnt    <= '0;
    end else if (line_end) begin
      h_count <= '0;
      if (frame_end) begin
        v_count <= '0;
        fcnt    <= fcnt + 8'd1;
      end else begin
        v_count <= v_count + TW'(1);
      end
    end else begin
      h_count <= h_count + TW'(1);
    end
  end

  // Pattern select only changes on the first pixel so a frame is never mixed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 2'd0;
    end else if (first_px) begin
      mode_q <= mode;
    end
  end

  // Stage 1: raw timing, coordinates and first-pixel marker
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_act   <= 1'b0;
      s1_first <= 1'b0;
      s1_px    <= '0;
      s1_py    <= '0;
      s1_fcnt  <= '0;
    end else begin
      s1_hs    <= hs_raw;
      s1_vs    <= vs_raw;
      s1_act   <= act;
      s1_first <= first_px;
      s1_px    <= px;
      s1_py    <= py;
      s1_fcnt  <= fcnt;
    end
  end

`ifdef VPG_BORDER_EN
  // Stage 1 border flag travels alongside the coordinates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_border <= 1'b0;
    end else begin
      s1_border <= border_raw;
    end
  end
`endif

  assign bar         = s1_px[BAR_SHIFT+2:BAR_SHIFT];
  assign grid_on     = (s1_px[GRID_SHIFT-1:0] == '0) || (s1_py[GRID_SHIFT-1:0] == '0);
  assign unused_bits = ^{s1_px, s1_py};

  // Colour for the stage-1 pixel; black outside the active window
  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    if (s1_act) begin
      case (mode_q)
        2'd0: pat_r = s1_px[CW-1:0];
        2'd1: begin
          // bar order white, yellow, cyan, green, magenta, red, blue, black
          pat_r = {CW{~bar[1]}};
          pat_g = {CW{~bar[2]}};
          pat_b = {CW{~bar[0]}};
        end
        2'd2: begin
          if (grid_on) begin
            pat_r = '1;
            pat_g = '1;
            pat_b = '1;
          end
        end
        default: {pat_r, pat_g, pat_b} = solid_rgb;
      endcase
`ifdef VPG_BORDER_EN
      if (s1_border) begin
        pat_r = '1;
        pat_g = '1;
        pat_b = '1;
      end
`endif
    end
  end

  // Stage 2: registered outputs, all aligned to the same counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs      <= ~HS_ACT;
      vga_vs      <= ~VS_ACT;
      vga_de      <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= s1_hs ? HS_ACT : ~HS_ACT;
      vga_vs      <= s1_vs ? VS_ACT : ~VS_ACT;
      vga_de      <= s1_act;
      vga_r       <= pat_r;
      vga_g       <= pat_g;
      vga_b       <= pat_b;
      frame_cnt   <= s1_fcnt;
      frame_start <= s1_first;
    end
  end

endmodule
